// File: rtl/cnn_frame_sequencer_if.sv
// Frame-sequencer bus: start/status, frame-buffer read port,
// CNN datapath pixel stream and classification result.
interface cnn_frame_sequencer_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 mem_rd;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_rdata;
  logic                 pix_val;
  logic [DATA_BITS-1:0] pix_data;
  logic                 cnn_out_val;
  logic [3:0]           cnn_decision;
  logic [3:0]           result;
  logic                 result_err;

  modport master (
    output start,
    output mem_rdata,
    output cnn_out_val,
    output cnn_decision,
    input  busy,
    input  done,
    input  mem_rd,
    input  mem_addr,
    input  pix_val,
    input  pix_data,
    input  result,
    input  result_err
  );

  modport slave (
    input  start,
    input  mem_rdata,
    input  cnn_out_val,
    input  cnn_decision,
    output busy,
    output done,
    output mem_rd,
    output mem_addr,
    output pix_val,
    output pix_data,
    output result,
    output result_err
  );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Streams one frame from the buffer into the CNN and latches its class.
// Define CNN_SEQ_TIMEOUT_EN to bound the decision wait (result 4'hF).
module cnn_frame_sequencer #(
  parameter int IMG_PIXELS     = 784,
  parameter int DATA_BITS      = 8,
  parameter int ADDR_BITS      = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic rst_n,
  cnn_frame_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    WAIT,
    DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST =
    ADDR_BITS'(IMG_PIXELS - 1);

  state_t               state;
  logic                 busy_q;
  logic                 done_q;
  logic                 mem_rd_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic                 pix_val_q;
  logic [DATA_BITS-1:0] pix_data_q;
  logic [3:0]           result_q;

`ifdef CNN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST =
    TW'(TIMEOUT_CYCLES - 1);

  logic          err_q;
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      pix_val_q  <= 1'b0;
      pix_data_q <= '0;
      result_q   <= 4'h0;
`ifdef CNN_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
      tcnt       <= '0;
`endif
    end else begin
      pix_val_q  <= mem_rd_q;
      pix_data_q <= bus.mem_rdata;
      done_q     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= STREAM;
            busy_q <= 1'b1;
          end
        end
        // first STREAM cycle arms the read port at address 0
        STREAM: begin
          if (!mem_rd_q) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= '0;
          end else if (mem_addr_q == LAST) begin
            mem_rd_q <= 1'b0;
            state    <= DRAIN;
          end else begin
            mem_addr_q <= mem_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          state <= WAIT;
`ifdef CNN_SEQ_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        WAIT: begin
          if (bus.cnn_out_val) begin
            result_q <= bus.cnn_decision;
            state    <= DONE;
            done_q   <= 1'b1;
`ifdef CNN_SEQ_TIMEOUT_EN
            err_q    <= 1'b0;
          end else if (tcnt == TLAST) begin
            result_q <= 4'hF;
            err_q    <= 1'b1;
            state    <= DONE;
            done_q   <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
`endif
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.pix_val  = pix_val_q;
  assign bus.pix_data = pix_data_q;
  assign bus.result   = result_q;
`ifdef CNN_SEQ_TIMEOUT_EN
  assign bus.result_err = err_q;
`else
  assign bus.result_err = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: frames, restart,
// early decision, mid-frame reset and (optional) decision timeout.
module tb_cnn_frame_sequencer;

  localparam int IMG = 784;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cnn_frame_sequencer_if #(
    .DATA_BITS(8),
    .ADDR_BITS(10)
  ) bus ();

  cnn_frame_sequencer #(
    .IMG_PIXELS(IMG),
    .DATA_BITS(8),
    .ADDR_BITS(10),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // frame buffer holds addr[7:0]
  assign bus.mem_rdata = bus.mem_addr[7:0];

  int checks = 0;
  int failures = 0;

  logic       mon_clr = 1'b1;
  int         pix_cnt;
  int         pix_bad;
  int         done_cnt;
  logic [7:0] exp_pix;

  always @(negedge clk) begin
    if (mon_clr) begin
      pix_cnt  <= 0;
      pix_bad  <= 0;
      done_cnt <= 0;
      exp_pix  <= 8'h00;
    end else begin
      if (bus.pix_val) begin
        pix_cnt <= pix_cnt + 1;
        exp_pix <= exp_pix + 8'h01;
        if (bus.pix_data !== exp_pix)
          pix_bad <= pix_bad + 1;
      end
      if (bus.done)
        done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    @(posedge clk);
    mon_clr = 1'b1;
    @(posedge clk);
    mon_clr = 1'b0;
    @(negedge clk);
  endtask

  // lat: edges from the start-sampling edge to done
  // fall: negedge index of the first WAIT cycle
  task automatic run_frame(input int ans,
                           input logic [3:0] dec,
                           input bit early,
                           input bit hold,
                           output int lat,
                           output int fall);
    int cyc;
    bit pv_prev;
    lat = -1;
    fall = -1;
    cyc = 0;
    pv_prev = 1'b0;
    bus.start = 1'b1;
    while (cyc < 3000 && lat < 0) begin
      @(negedge clk);
      cyc++;
      if (!hold) bus.start = 1'b0;
      if (pv_prev && !bus.pix_val && fall < 0)
        fall = cyc;
      pv_prev = bus.pix_val;
      bus.cnn_out_val = 1'b0;
      bus.cnn_decision = dec;
      if (early && cyc >= 10 && cyc < 20) begin
        bus.cnn_out_val = 1'b1;
        bus.cnn_decision = 4'd7;
      end
      if (fall >= 0 && ans >= 0 && cyc == fall + ans)
        bus.cnn_out_val = 1'b1;
      if (bus.done) lat = cyc - 1;
    end
    bus.cnn_out_val = 1'b0;
    chk("done_within_bound", 32'(lat >= 0), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_mem_rd"}, 32'(bus.mem_rd), 0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_pix_val"}, 32'(bus.pix_val), 0);
    chk({tag, "_pix_data"}, 32'(bus.pix_data), 0);
    chk({tag, "_result"}, 32'(bus.result), 0);
    chk({tag, "_result_err"}, 32'(bus.result_err), 0);
  endtask

  initial begin
    int lat;
    int fall;
    int n;
    bus.start = 1'b0;
    bus.cnn_out_val = 1'b0;
    bus.cnn_decision = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // normal frame, answer 2 cycles after last pix_val
    clr_mon();
    run_frame(1, 4'd3, 1'b0, 1'b0, lat, fall);
    chk("t1_latency", 32'(lat), IMG + 4);
    chk("t1_result", 32'(bus.result), 3);
    repeat (3) @(negedge clk);
    chk("t1_busy_after", 32'(bus.busy), 0);
    chk("t1_pix_cnt", 32'(pix_cnt), IMG);
    chk("t1_pix_bad", 32'(pix_bad), 0);
    chk("t1_done_cnt", 32'(done_cnt), 1);
    chk("t1_err", 32'(bus.result_err), 0);

    // minimum latency: answer in first WAIT cycle
    clr_mon();
    run_frame(0, 4'd6, 1'b0, 1'b0, lat, fall);
    chk("t2_latency", 32'(lat), IMG + 3);
    chk("t2_result", 32'(bus.result), 6);

    // early out_val during STREAM is ignored
    clr_mon();
    run_frame(1, 4'd5, 1'b1, 1'b0, lat, fall);
    chk("t3_result", 32'(bus.result), 5);

    // reset at pixel 400
    clr_mon();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (pix_cnt < 400 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reached_400", 32'(n < 2000), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero("t4_midreset");
    repeat (20) @(negedge clk);
    chk("t4_no_resume", 32'(bus.busy), 0);
    chk("t4_no_done", 32'(done_cnt), 0);
    clr_mon();
    run_frame(1, 4'd2, 1'b0, 1'b0, lat, fall);
    chk("t4_pix_cnt", 32'(pix_cnt), IMG);
    chk("t4_pix_bad", 32'(pix_bad), 0);
    chk("t4_result", 32'(bus.result), 2);

    // start held high for the whole frame
    clr_mon();
    run_frame(1, 4'd4, 1'b0, 1'b1, lat, fall);
    chk("t5_latency", 32'(lat), IMG + 4);
    @(negedge clk);
    chk("t5_idle_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("t5_restart_busy", 32'(bus.busy), 1);
    chk("t5_restart_rd0", 32'(bus.mem_rd), 0);
    @(negedge clk);
    chk("t5_restart_rd1", 32'(bus.mem_rd), 1);
    chk("t5_restart_addr", 32'(bus.mem_addr), 0);
    chk("t5_one_frame", 32'(pix_cnt), IMG);
    chk("t5_done_cnt", 32'(done_cnt), 1);
    bus.start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CNN_SEQ_TIMEOUT_EN
    // no answer: timeout 16 cycles after WAIT entry
    clr_mon();
    run_frame(-1, 4'd0, 1'b0, 1'b0, lat, fall);
    chk("t6_wait_len", 32'(lat - fall + 1), 16);
    chk("t6_result", 32'(bus.result), 4'hF);
    chk("t6_err", 32'(bus.result_err), 1);

    // answer in 16th WAIT cycle wins over timeout
    clr_mon();
    run_frame(15, 4'd9, 1'b0, 1'b0, lat, fall);
    chk("t7_wait_len", 32'(lat - fall + 1), 16);
    chk("t7_result", 32'(bus.result), 9);
    chk("t7_err", 32'(bus.result_err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
